// File: rtl/mem_responder_pkg.sv
// Shared types for the mem_responder slice: access-size encoding and responder FSM states.
package mem_responder_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [2:0] {
        B  = 3'b000,
        H  = 3'b001,
        W  = 3'b010,
        BU = 3'b100,
        HU = 3'b101
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } resp_state_e;

endpackage

// File: rtl/mem_responder_load_store_align.sv
// Combinational lane steering: merges store data into the old word and extracts/extends load data.
module load_store_align
    import mem_responder_pkg::*;
(
    input  logic [2:0]      i_size,
    input  logic [1:0]      i_addr_lo,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [XLEN-1:0] i_old_word,
    output logic [XLEN-1:0] o_store_word_c,
    output logic [3:0]      o_byte_en_c,
    output logic [XLEN-1:0] o_load_data_c
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_old_word[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_old_word[{i_addr_lo[1], 4'b0000} +: 16];

    // Halfword lane uses addr[1] only and word ignores addr[1:0], so misaligned accesses align down.
    always_comb begin
        o_store_word_c = i_wdata;
        o_byte_en_c    = 4'b1111;
        o_load_data_c  = i_old_word;
        case (i_size)
            B, BU: begin
                o_store_word_c = i_old_word;
                o_store_word_c[{i_addr_lo, 3'b000} +: 8] = i_wdata[7:0];
                o_byte_en_c    = 4'(4'b0001 << i_addr_lo);
                o_load_data_c  = (i_size == B) ? {{24{w_byte[7]}}, w_byte} : {24'h0, w_byte};
            end
            H, HU: begin
                o_store_word_c = i_old_word;
                o_store_word_c[{i_addr_lo[1], 4'b0000} +: 16] = i_wdata[15:0];
                o_byte_en_c    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_load_data_c  = (i_size == H) ? {{16{w_half[15]}}, w_half} : {16'h0, w_half};
            end
            default: begin
                o_store_word_c = i_wdata;
                o_byte_en_c    = 4'b1111;
                o_load_data_c  = i_old_word;
            end
        endcase
    end

endmodule

// File: rtl/mem_responder.sv
// Multi-cycle load/store memory responder with programmable wait states.
// Optional MEM_RESPONDER_ERR_CHECK_EN enables misalign/range/size error reporting.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS       = 1024,
    parameter int unsigned WAIT_STATES       = 1,
    parameter string       MEM_INIT_FILENAME = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned CW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;

    resp_state_e     r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_write;
    logic [2:0]      r_size;
    logic [31:0]     r_addr;
    logic [31:0]     r_wdata;
    logic            r_rsp_valid;
    logic [31:0]     r_rdata;
    logic            r_error;
    logic [XLEN-1:0] r_mem [DEPTH_WORDS];

    logic            w_from_req;
    logic            w_acc_write;
    logic [2:0]      w_acc_size;
    logic [31:0]     w_acc_addr;
    logic [31:0]     w_acc_wdata;
    logic [AW-1:0]   w_idx;
    logic [31:0]     w_old_word;
    logic [31:0]     w_store_word;
    logic [3:0]      w_byte_en;
    logic [31:0]     w_load_data;
    logic            w_enter_resp;
    logic            w_err;

    assign req_ready = (r_state == IDLE) && !reset;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rdata;
    assign rsp_error = r_error;

    // With zero wait states the access happens on the accept edge, so it uses the live request.
    assign w_from_req  = (r_state == IDLE);
    assign w_acc_write = w_from_req ? req_write : r_write;
    assign w_acc_size  = w_from_req ? req_size  : r_size;
    assign w_acc_addr  = w_from_req ? req_addr  : r_addr;
    assign w_acc_wdata = w_from_req ? req_wdata : r_wdata;
    assign w_idx       = w_acc_addr[AW+1:2];
    assign w_old_word  = r_mem[w_idx];

    assign w_enter_resp = ((r_state == IDLE) && req_valid && (WAIT_STATES == 0)) ||
                          ((r_state == WAIT) && (r_cnt == '0));

`ifdef MEM_RESPONDER_ERR_CHECK_EN
    always_comb begin
        w_err = 1'b0;
        case (w_acc_size)
            B:       w_err = 1'b0;
            BU:      w_err = w_acc_write;
            H:       w_err = w_acc_addr[0];
            HU:      w_err = w_acc_addr[0] | w_acc_write;
            W:       w_err = (w_acc_addr[1:0] != 2'b00);
            default: w_err = 1'b1;
        endcase
        if (w_acc_addr[31:AW+2] != '0) w_err = 1'b1;
    end
`else
    logic w_unused_addr;
    assign w_err         = 1'b0;
    assign w_unused_addr = ^w_acc_addr[31:AW+2];
`endif

    load_store_align u_align (
        .i_size         (w_acc_size),
        .i_addr_lo      (w_acc_addr[1:0]),
        .i_wdata        (w_acc_wdata),
        .i_old_word     (w_old_word),
        .o_store_word_c (w_store_word),
        .o_byte_en_c    (w_byte_en),
        .o_load_data_c  (w_load_data)
    );

    // Responder FSM; array contents are deliberately untouched by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_rdata     <= '0;
            r_error     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_write <= req_write;
                        r_size  <= req_size;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        if (WAIT_STATES > 0) begin
                            r_state <= WAIT;
                            r_cnt   <= CW'(WAIT_STATES - 1);
                        end else begin
                            r_state <= RESP;
                        end
                    end
                end
                WAIT: begin
                    if (r_cnt == '0) r_state <= RESP;
                    else             r_cnt   <= r_cnt - 1'b1;
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_state     <= IDLE;
                        r_rsp_valid <= 1'b0;
                        r_rdata     <= '0;
                        r_error     <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase

            if (w_enter_resp) begin
                r_rsp_valid <= 1'b1;
                r_error     <= w_err;
                r_rdata     <= (!w_acc_write && !w_err) ? w_load_data : '0;
                if (w_acc_write && !w_err && (w_byte_en != 4'b0000)) r_mem[w_idx] <= w_store_word;
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed table, multi-cycle corner cases, random vs byte-array model.
module tb_mem_responder;

    localparam int unsigned DEPTH = 256;
`ifdef MEM_RESPONDER_ERR_CHECK_EN
    localparam bit ERRCHK = 1'b1;
`else
    localparam bit ERRCHK = 1'b0;
`endif

    logic        clk;
    logic        rst       [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_write [2];
    logic [2:0]  req_size  [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_error [2];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [7:0] mdl [2][DEPTH*4];

    // sel 0: one wait state, sel 1: zero wait states
    mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(1), .MEM_INIT_FILENAME("")) u_dut_ws1 (
        .clk(clk), .reset(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_write(req_write[0]), .req_size(req_size[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_error(rsp_error[0])
    );

    mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0), .MEM_INIT_FILENAME("")) u_dut_ws0 (
        .clk(clk), .reset(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_write(req_write[1]), .req_size(req_size[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_error(rsp_error[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: little-endian byte array, rules taken directly from the access definitions.
    task automatic model(input int sel, input logic w, input logic [2:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] rd, output logic er);
        int unsigned nb;
        bit          sgn;
        bit          bad_size;
        logic [31:0] ea;
        logic [31:0] val;
        nb = 4; sgn = 1'b0; bad_size = 1'b0;
        case (sz)
            3'd0: begin nb = 1; sgn = 1'b1; end
            3'd1: begin nb = 2; sgn = 1'b1; end
            3'd2: nb = 4;
            3'd4: nb = 1;
            3'd5: nb = 2;
            default: bad_size = 1'b1;
        endcase
        rd = 32'h0;
        er = 1'b0;
        if (ERRCHK) begin
            er = bad_size || (w && (sz == 3'd4 || sz == 3'd5)) || ((a % nb) != 0) || ((a / 4) >= DEPTH);
            ea = a;
        end else begin
            ea = (a - (a % nb)) % (DEPTH * 4);
        end
        if (!er) begin
            if (w) begin
                for (int i = 0; i < int'(nb); i++) mdl[sel][ea + i] = wd[8*i +: 8];
            end else begin
                val = 32'h0;
                for (int i = 0; i < int'(nb); i++) val = val | ({24'h0, mdl[sel][ea + i]} << (8 * i));
                if (sgn && val[8*nb-1]) val = val | (32'hFFFF_FFFF << (8 * nb));
                rd = val;
            end
        end
    endtask

    // One full transaction with latency, hold-stability and turnaround checks.
    task automatic txn(input int sel, input logic w, input logic [2:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, input int hold,
                       output logic [31:0] rd, output logic er, output int acc);
        int n;
        req_write[sel] = w; req_size[sel] = sz; req_addr[sel] = a; req_wdata[sel] = wd;
        req_valid[sel] = 1'b1;
        n = 0;
        while (!req_ready[sel] && n < 20) begin @(posedge clk); #1; n++; end
        chk("req_ready before accept", 32'(req_ready[sel]), 32'h1);
        @(posedge clk);
        #1;
        acc = cyc;
        req_valid[sel] = 1'b0;
        req_write[sel] = 1'($urandom); req_size[sel] = 3'($urandom);
        req_addr[sel] = $urandom; req_wdata[sel] = $urandom;
        n = 0;
        while (!rsp_valid[sel] && n < 20) begin @(posedge clk); #1; n++; end
        chk("response latency", 32'(n), (sel == 0) ? 32'd1 : 32'd0);
        rd = rsp_rdata[sel];
        er = rsp_error[sel];
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            chk("hold rsp_valid", 32'(rsp_valid[sel]), 32'h1);
            chk("hold rsp_rdata", rsp_rdata[sel], rd);
            chk("hold rsp_error", 32'(rsp_error[sel]), 32'(er));
            chk("hold req_ready", 32'(req_ready[sel]), 32'h0);
        end
        rsp_ready[sel] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready[sel] = 1'b0;
        chk("rsp_valid after handshake", 32'(rsp_valid[sel]), 32'h0);
        chk("req_ready after handshake", 32'(req_ready[sel]), 32'h1);
    endtask

    task automatic run(input int sel, input logic w, input logic [2:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, input int hold,
                       output logic [31:0] rd, output logic er, output int acc);
        logic [31:0] mrd;
        logic        mer;
        txn(sel, w, sz, a, wd, hold, rd, er, acc);
        model(sel, w, sz, a, wd, mrd, mer);
        chk("model rdata", rd, mrd);
        chk("model error", 32'(er), 32'(mer));
    endtask

    typedef struct {
        logic        w;
        logic [2:0]  sz;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_er;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vecs [NVEC];

    initial begin
        logic [31:0] rd;
        logic        er;
        int          acc_a;
        int          acc_b;
        logic [2:0]  sz;
        logic        w;
        logic [31:0] a;
        int          pick;
        logic [2:0]  sizes [5];

        vecs[0]  = '{1'b1, 3'b010, 32'h0,   32'h8899AABB, 32'h0, 1'b0};
        vecs[1]  = '{1'b0, 3'b000, 32'h3,   32'h0, 32'hFFFFFF88, 1'b0};
        vecs[2]  = '{1'b0, 3'b100, 32'h3,   32'h0, 32'h00000088, 1'b0};
        vecs[3]  = '{1'b0, 3'b000, 32'h0,   32'h0, 32'hFFFFFFBB, 1'b0};
        vecs[4]  = '{1'b0, 3'b100, 32'h1,   32'h0, 32'h000000AA, 1'b0};
        vecs[5]  = '{1'b0, 3'b001, 32'h2,   32'h0, 32'hFFFF8899, 1'b0};
        vecs[6]  = '{1'b0, 3'b101, 32'h0,   32'h0, 32'h0000AABB, 1'b0};
        vecs[7]  = '{1'b1, 3'b010, 32'h4,   32'h11223344, 32'h0, 1'b0};
        vecs[8]  = '{1'b1, 3'b001, 32'h6,   32'h1234CAFE, 32'h0, 1'b0};
        vecs[9]  = '{1'b0, 3'b101, 32'h6,   32'h0, 32'h0000CAFE, 1'b0};
        vecs[10] = '{1'b0, 3'b010, 32'h4,   32'h0, 32'hCAFE3344, 1'b0};
        vecs[11] = '{1'b1, 3'b000, 32'h5,   32'h000000A5, 32'h0, 1'b0};
        vecs[12] = '{1'b0, 3'b010, 32'h4,   32'h0, 32'hCAFEA544, 1'b0};
        vecs[13] = '{1'b0, 3'b010, 32'h2,   32'h0, ERRCHK ? 32'h0 : 32'h8899AABB, ERRCHK};
        vecs[14] = '{1'b0, 3'b001, 32'h1,   32'h0, ERRCHK ? 32'h0 : 32'hFFFFAABB, ERRCHK};
        vecs[15] = '{1'b0, 3'b011, 32'h0,   32'h0, ERRCHK ? 32'h0 : 32'h8899AABB, ERRCHK};
        vecs[16] = '{1'b0, 3'b010, 32'h400, 32'h0, ERRCHK ? 32'h0 : 32'h8899AABB, ERRCHK};
        vecs[17] = '{1'b1, 3'b001, 32'h7,   32'h00005555, 32'h0, ERRCHK};
        vecs[18] = '{1'b0, 3'b010, 32'h4,   32'h0, ERRCHK ? 32'hCAFEA544 : 32'h5555A544, 1'b0};
        vecs[19] = '{1'b1, 3'b000, 32'h3FF, 32'h0000007F, 32'h0, 1'b0};
        vecs[20] = '{1'b0, 3'b100, 32'h3FF, 32'h0, 32'h0000007F, 1'b0};

        sizes[0] = 3'b000; sizes[1] = 3'b001; sizes[2] = 3'b010; sizes[3] = 3'b100; sizes[4] = 3'b101;

        for (int s = 0; s < 2; s++) begin
            rst[s] = 1'b1; req_valid[s] = 1'b0; req_write[s] = 1'b0; req_size[s] = 3'b0;
            req_addr[s] = 32'h0; req_wdata[s] = 32'h0; rsp_ready[s] = 1'b0;
        end

        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            chk("reset req_ready", 32'(req_ready[s]), 32'h0);
            chk("reset rsp_valid", 32'(rsp_valid[s]), 32'h0);
            chk("reset rsp_rdata", rsp_rdata[s], 32'h0);
            chk("reset rsp_error", 32'(rsp_error[s]), 32'h0);
        end
        rst[0] = 1'b0; rst[1] = 1'b0;
        #1;
        for (int s = 0; s < 2; s++) chk("req_ready after reset", 32'(req_ready[s]), 32'h1);

        // Directed table on the one-wait-state instance
        for (int i = 0; i < NVEC; i++) begin
            run(0, vecs[i].w, vecs[i].sz, vecs[i].a, vecs[i].wd, 0, rd, er, acc_a);
            chk($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rd);
            chk($sformatf("vec%0d error", i), 32'(er), 32'(vecs[i].exp_er));
        end

        // Response held off for five cycles
        run(0, 1'b0, 3'b010, 32'h0, 32'h0, 5, rd, er, acc_a);
        chk("held LW rdata", rd, 32'h8899AABB);

        // Zero wait states: back-to-back store then load
        run(1, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, rd, er, acc_a);
        run(1, 1'b0, 3'b010, 32'h10, 32'h0, 0, rd, er, acc_b);
        chk("ws0 LW rdata", rd, 32'hDEADBEEF);
        chk("ws0 accept spacing", 32'(acc_b - acc_a), 32'd2);

        // One-wait-state spacing is three cycles
        run(0, 1'b1, 3'b010, 32'h20, 32'h5A5A5A5A, 0, rd, er, acc_a);
        run(0, 1'b0, 3'b010, 32'h20, 32'h0, 0, rd, er, acc_b);
        chk("ws1 accept spacing", 32'(acc_b - acc_a), 32'd3);

        // Reset during WAIT drops the store
        req_write[0] = 1'b1; req_size[0] = 3'b010; req_addr[0] = 32'h20; req_wdata[0] = 32'hFFFF0000;
        req_valid[0] = 1'b1;
        chk("drop: req_ready", 32'(req_ready[0]), 32'h1);
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        rst[0] = 1'b1;
        #1;
        chk("drop: req_ready in reset", 32'(req_ready[0]), 32'h0);
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        #1;
        chk("drop: rsp_valid", 32'(rsp_valid[0]), 32'h0);
        chk("drop: req_ready", 32'(req_ready[0]), 32'h1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk("drop: no response", 32'(rsp_valid[0]), 32'h0);
        end
        run(0, 1'b0, 3'b010, 32'h20, 32'h0, 0, rd, er, acc_a);
        chk("drop: word 8 unchanged", rd, 32'h5A5A5A5A);

        // Fill both arrays so every word the random phase can reach is known
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < int'(DEPTH); i++)
                run(s, 1'b1, 3'b010, 32'(i * 4), $urandom, 0, rd, er, acc_a);

        for (int t = 0; t < 300; t++) begin
            pick = int'($urandom_range(0, 9));
            sz = (pick < 8) ? sizes[$urandom_range(0, 4)] : 3'($urandom_range(0, 7));
            w = 1'($urandom);
            if (!ERRCHK && w && (sz == 3'b100 || sz == 3'b101)) sz = sz - 3'd4;
            a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 255));
            run(t % 2, w, sz, a, $urandom, int'($urandom_range(0, 2)), rd, er, acc_a);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
